id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding M_alu operands a, b and alucontrol.
//  - Captures decoded fields from decode and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Inserts load-use bubbles and honours a valid/ready handshake with execute.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register index width
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high reset
//  in_valid       in   1      decode presents an instruction
//  in_ready       out  1      stage can accept this cycle
//  flush          in   1      kill stage contents (branch/jump redirect)
//  id_pc          in   XLEN   instruction PC
//  id_rs1,id_rs2  in   REG_AW source register indices
//  id_rs1_data    in   XLEN   regfile read data, port 1
//  id_rs2_data    in   XLEN   regfile read data, port 2
//  id_imm         in   XLEN   sign-extended immediate
//  id_srca_sel    in   2      0=rs1, 1=pc, 2=zero, 3=rsvd(zero)
//  id_srcb_imm    in   1      1=imm, 0=rs2
//  id_alucontrol  in   4      ALU op code
//  id_rd          in   REG_AW destination index
//  id_regwrite    in   1      instruction writes rd
//  id_uses_rs1    in   1      rs1 is a real source
//  id_uses_rs2    in   1      rs2 is a real source
//  exm_regwrite   in   1      EX/MEM will write back
//  exm_rd         in   REG_AW EX/MEM destination
//  exm_result     in   XLEN   EX/MEM ALU result
//  exm_is_load    in   1      EX/MEM holds a load; its data is not yet available
//  wb_regwrite    in   1      MEM/WB writes back
//  wb_rd          in   REG_AW MEM/WB destination
//  wb_result      in   XLEN   MEM/WB final write-back value
//  ex_ready       in   1      execute accepts this cycle
//  out_valid      out  1      a/b/alucontrol valid for execute
//  a, b           out  XLEN   ALU operands
//  alucontrol     out  4      ALU op code
//  ex_rd          out  REG_AW destination passed on
//  ex_regwrite    out  1      regwrite qualified by out_valid
//  ex_pc          out  XLEN   PC passed on
//  ex_rs2_val     out  XLEN   forwarded rs2 for store data
// BEHAVIOUR
//  Reset: valid_q=0; all registered fields=0. Outputs: out_valid=0, a=b=0, alucontrol=4'b0010 (ADD), ex_regwrite=0.
//  Load: stage loads on in_valid&&in_ready, one-cycle latency; operands appear the cycle after capture.
//  Ready: in_ready = !valid_q || (ex_ready && !luh).
//  Transfer: out_valid = valid_q && !luh; a transfer occurs on out_valid && ex_ready.
//  Forwarding: combinational on stored rs1/rs2 every cycle.
//  - Priority: EX/MEM over MEM/WB over stored value.
//  - A source matches only when regwrite=1 and rd!=0. Index 0 is never forwarded; it always reads 0.
//  Load-use (luh): valid_q and the EX/MEM load's rd matches a used source (rd!=0).
//  - Bubble: out_valid=0 and the stage holds.
//  - Next cycle the load is in MEM/WB and forwards from wb_result.
//  Hold refresh: while valid_q and no transfer, stored rs1/rs2 values take the forwarded value each cycle.
//  - This keeps a producer that retires past WB during a stall.
//  Operand select:
//  - a = srca_sel? (pc | 0) : fwd_rs1.
//  - b = srcb_imm? imm : fwd_rs2.
//  - ex_rs2_val = fwd_rs2 always.
//  Flush: valid_q<=0 next cycle, including mid-hold. It overrides a simultaneous load, and in_ready is ignored.
//  Reset mid-operation: the same as flush, and all fields clear.
//  Simultaneous transfer and load: the new instruction replaces the old with no bubble. This gives full throughput.
//  alucontrol: passed unmodified.
//  - 0000 XOR, 0001 SLL, 0010 ADD, 0011 AND.
//  - 0100 SRA, 0101 SRL, 0110 SUB, 1000 OR.
// STRUCTURE
//  riscv_pkg: ALU_* localparams for the codes above; srca_sel_e enum; fwd_sel_e {FWD_NONE,FWD_EXM,FWD_WB}.
//  Sub-module fwd_unit: one instance per source.
//  - Inputs: rs, uses, stored value, EX/MEM and MEM/WB fields.
//  - Outputs: value, fwd_sel, and a load-use hit.
// TESTING
//  1 Plain ADD: rs1_data=1, rs2_data=2, alucontrol=0010 -> next cycle out_valid=1, a=1, b=2.
//  2 EX/MEM forward: rs1=5, exm_rd=5, exm_result=0x55 with wb_rd=5, wb_result=0x11 -> a=0x55; rd=0 case -> a=regfile value.
//  3 Load-use: exm_is_load, exm_rd=rs2=7 -> one bubble, in_ready=0; next cycle wb_result=0xAA -> b=0xAA, out_valid=1.
//  4 Stall refresh: ex_ready=0 for 3 cycles while WB writes rs1=0x800000 then retires -> a=0x800000 when ex_ready rises.
//  5 Flush during hold: valid_q=1, ex_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, nothing captured.
//  6 Back-to-back: 8 instructions with ex_ready=1 -> 8 consecutive out_valid cycles; reset mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared types and constants for the ID/EX pipeline register.
//   ALU_*       : ALU operation codes carried through to execute unmodified
//   srca_sel_e  : operand A source select (rs1, pc, zero, reserved->zero)
//   fwd_sel_e   : which pipeline stage supplied a forwarded source value
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_XOR = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b1000;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2,
        SRCA_RSVD = 2'd3
    } srca_sel_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // True when op is one of the ALU codes execute understands.
    function automatic logic alu_op_known(input logic [3:0] op);
        return (op == ALU_XOR) || (op == ALU_SLL) || (op == ALU_ADD) ||
               (op == ALU_AND) || (op == ALU_SRA) || (op == ALU_SRL) ||
               (op == ALU_SUB) || (op == ALU_OR);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle of every non-clock signal of the ID/EX stage.
//   decode side   : in_valid/in_ready handshake, flush, id_* decoded fields
//   hazard side   : exm_* (EX/MEM) and wb_* (MEM/WB) write-back information
//   execute side  : out_valid/ex_ready handshake, a/b/alucontrol, ex_* fields
// master = surrounding pipeline, slave = the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [1:0]        id_srca_sel;
    logic              id_srcb_imm;
    logic [3:0]        id_alucontrol;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              exm_regwrite;
    logic [REG_AW-1:0] exm_rd;
    logic [XLEN-1:0]   exm_result;
    logic              exm_is_load;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_result;
    logic              ex_ready;
    logic              out_valid;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [3:0]        alucontrol;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs2_val;

    modport master (
        output in_valid, flush, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_imm, id_srca_sel, id_srcb_imm, id_alucontrol, id_rd,
               id_regwrite, id_uses_rs1, id_uses_rs2,
               exm_regwrite, exm_rd, exm_result, exm_is_load,
               wb_regwrite, wb_rd, wb_result, ex_ready,
        input  in_ready, out_valid, a, b, alucontrol, ex_rd, ex_regwrite,
               ex_pc, ex_rs2_val
    );

    modport slave (
        input  in_valid, flush, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_imm, id_srca_sel, id_srcb_imm, id_alucontrol, id_rd,
               id_regwrite, id_uses_rs1, id_uses_rs2,
               exm_regwrite, exm_rd, exm_result, exm_is_load,
               wb_regwrite, wb_rd, wb_result, ex_ready,
        output in_ready, out_valid, a, b, alucontrol, ex_rd, ex_regwrite,
               ex_pc, ex_rs2_val
    );
endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// id_ex_stage_fwd_unit: operand forwarding for one source register.
//   rs_i, uses_i, stored_i     : source index, real-source flag, held value
//   exm_* / wb_*               : producer information from EX/MEM and MEM/WB
//   value_o                    : resolved operand (x0 always reads 0)
//   sel_o                      : which stage supplied value_o
//   luh_o                      : source depends on a load still in EX/MEM
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              uses_i,
    input  logic [XLEN-1:0]   stored_i,
    input  logic              exm_regwrite_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic              exm_is_load_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_result_i,
    output logic [XLEN-1:0]   value_o,
    output fwd_sel_e          sel_o,
    output logic              luh_o
);
    always_comb begin
        sel_o   = FWD_NONE;
        value_o = stored_i;
        if (rs_i == '0) begin
            value_o = '0;
        end else if (exm_regwrite_i && (exm_rd_i == rs_i)) begin
            sel_o   = FWD_EXM;
            value_o = exm_result_i;
        end else if (wb_regwrite_i && (wb_rd_i == rs_i)) begin
            sel_o   = FWD_WB;
            value_o = wb_result_i;
        end
    end

    assign luh_o = uses_i && exm_is_load_i && (rs_i != '0) && (exm_rd_i == rs_i);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   clk, reset : clock, synchronous active-high reset
//   bus        : id_ex_stage_if slave (decode handshake and fields, EX/MEM and
//                MEM/WB forwarding sources, execute handshake and operands)
// Operands are forwarded combinationally from the stored source indices every
// cycle; a load in EX/MEM feeding a used source inserts a bubble.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    import id_ex_stage_pkg::*;

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [XLEN-1:0]   rs1_val_q,  rs1_val_d;
    logic [XLEN-1:0]   rs2_val_q,  rs2_val_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    srca_sel_e         srca_sel_q, srca_sel_d;
    logic              srcb_imm_q, srcb_imm_d;
    logic [3:0]        aluc_q,     aluc_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic              regwrite_q, regwrite_d;
    logic              uses_rs1_q, uses_rs1_d;
    logic              uses_rs2_q, uses_rs2_d;

    logic [XLEN-1:0]   fwd1_val, fwd2_val;
    fwd_sel_e          fwd1_sel, fwd2_sel;
    logic              luh1, luh2, luh;
    logic              load, transfer, out_valid;
    logic [XLEN-1:0]   a_mux;

    id_ex_stage_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_i           (rs1_q),
        .uses_i         (uses_rs1_q),
        .stored_i       (rs1_val_q),
        .exm_regwrite_i (bus.exm_regwrite),
        .exm_rd_i       (bus.exm_rd),
        .exm_result_i   (bus.exm_result),
        .exm_is_load_i  (bus.exm_is_load),
        .wb_regwrite_i  (bus.wb_regwrite),
        .wb_rd_i        (bus.wb_rd),
        .wb_result_i    (bus.wb_result),
        .value_o        (fwd1_val),
        .sel_o          (fwd1_sel),
        .luh_o          (luh1)
    );

    id_ex_stage_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_i           (rs2_q),
        .uses_i         (uses_rs2_q),
        .stored_i       (rs2_val_q),
        .exm_regwrite_i (bus.exm_regwrite),
        .exm_rd_i       (bus.exm_rd),
        .exm_result_i   (bus.exm_result),
        .exm_is_load_i  (bus.exm_is_load),
        .wb_regwrite_i  (bus.wb_regwrite),
        .wb_rd_i        (bus.wb_rd),
        .wb_result_i    (bus.wb_result),
        .value_o        (fwd2_val),
        .sel_o          (fwd2_sel),
        .luh_o          (luh2)
    );

    assign luh          = valid_q && (luh1 || luh2);
    assign out_valid    = valid_q && !luh;
    assign transfer     = out_valid && bus.ex_ready;
    assign bus.in_ready = !valid_q || (bus.ex_ready && !luh);
    assign load         = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_d      = imm_q;
        srca_sel_d = srca_sel_q;
        srcb_imm_d = srcb_imm_q;
        aluc_d     = aluc_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        uses_rs1_d = uses_rs1_q;
        uses_rs2_d = uses_rs2_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            // A load coinciding with a transfer simply replaces the old entry.
            valid_d    = 1'b1;
            pc_d       = bus.id_pc;
            rs1_d      = bus.id_rs1;
            rs2_d      = bus.id_rs2;
            rs1_val_d  = bus.id_rs1_data;
            rs2_val_d  = bus.id_rs2_data;
            imm_d      = bus.id_imm;
            srca_sel_d = srca_sel_e'(bus.id_srca_sel);
            srcb_imm_d = bus.id_srcb_imm;
            aluc_d     = bus.id_alucontrol;
            rd_d       = bus.id_rd;
            regwrite_d = bus.id_regwrite;
            uses_rs1_d = bus.id_uses_rs1;
            uses_rs2_d = bus.id_uses_rs2;
        end else if (transfer) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // While held, absorb forwarded values so a producer that retires
            // past WB during the stall is not lost.
            if (fwd1_sel != FWD_NONE) rs1_val_d = fwd1_val;
            if (fwd2_sel != FWD_NONE) rs2_val_d = fwd2_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            srca_sel_q <= SRCA_RS1;
            srcb_imm_q <= 1'b0;
            aluc_q     <= ALU_ADD;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            uses_rs1_q <= 1'b0;
            uses_rs2_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_q      <= imm_d;
            srca_sel_q <= srca_sel_d;
            srcb_imm_q <= srcb_imm_d;
            aluc_q     <= aluc_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            uses_rs1_q <= uses_rs1_d;
            uses_rs2_q <= uses_rs2_d;
        end
    end

    always_comb begin
        case (srca_sel_q)
            SRCA_RS1: a_mux = fwd1_val;
            SRCA_PC:  a_mux = pc_q;
            default:  a_mux = '0;
        endcase
    end

    assign bus.out_valid   = out_valid;
    assign bus.a           = a_mux;
    assign bus.b           = srcb_imm_q ? imm_q : fwd2_val;
    assign bus.alucontrol  = aluc_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_regwrite = regwrite_q && out_valid;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs2_val  = fwd2_val;

endmodule
